rv32i_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences the shared datapath (PC, IR, register file, ALU, immediate generator, unified memory port) through fetch, decode, execute, memory and writeback. Each step drives the write enables, mux selects and immediate-format select. The controller also handles the memory port's req/ready handshake and stops in a sticky trap on unsupported opcodes.

---
 rtl/rv32i_pkg.sv | 73 +++++++
 rtl/rv32i_op_class.sv | 30 +++
 rtl/rv32i_multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rv32i_multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, datapath mux selects, controller states and
// the opcode-class payload produced by the decoder.
package rv32i_pkg;

    localparam int unsigned OPC_W    = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned CNT_W    = 32;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4    = 2'd0,
        PC_PLUS_IMM = 2'd1,
        PC_ALU      = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } ctrl_state_e;

    // One-hot opcode class; all zero means the opcode is not supported.
    typedef struct packed {
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic branch;
        logic load;
        logic store;
        logic op_imm;
        logic op;
        logic fence;
    } op_class_t;

    // Immediate format used by each instruction class.
    function automatic imm_sel_e imm_sel_for(input op_class_t c);
        if (c.store)            return IMM_S;
        if (c.branch)           return IMM_B;
        if (c.lui || c.auipc)   return IMM_U;
        if (c.jal)              return IMM_J;
        return IMM_I;
    endfunction

endpackage

// File: rtl/rv32i_op_class.sv
// Combinational opcode-to-class decoder with a legal-opcode flag.
module rv32i_op_class
    import rv32i_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        cls_c,
    output logic             legal_c
);

    // Map each supported opcode to exactly one class bit.
    always_comb begin
        cls_c = '0;
        case (opcode)
            OPC_LUI:    cls_c.lui    = 1'b1;
            OPC_AUIPC:  cls_c.auipc  = 1'b1;
            OPC_JAL:    cls_c.jal    = 1'b1;
            OPC_JALR:   cls_c.jalr   = 1'b1;
            OPC_BRANCH: cls_c.branch = 1'b1;
            OPC_LOAD:   cls_c.load   = 1'b1;
            OPC_STORE:  cls_c.store  = 1'b1;
            OPC_OP_IMM: cls_c.op_imm = 1'b1;
            OPC_OP:     cls_c.op     = 1'b1;
            OPC_FENCE:  cls_c.fence  = 1'b1;
            default:    cls_c        = '0;
        endcase
    end

    assign legal_c = |cls_c;

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/writeback over
// a shared datapath and a req/ready memory port; traps on unsupported opcodes.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module rv32i_multicycle_ctrl
    import rv32i_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic                br_taken,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                reg_we,
    output logic [1:0]          wb_sel,
    output logic                alu_a_sel,
    output logic                alu_b_sel,
    output logic [2:0]          imm_sel,
    output logic                illegal
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instret_cnt
`endif
);

    ctrl_state_e state_q, state_d;
    op_class_t   cls;
    logic        legal;

    logic        mem_req_c, mem_we_c, addr_sel_c, ir_we_c, pc_we_c, reg_we_c;
    logic        alu_a_sel_c, alu_b_sel_c, illegal_c;
    pc_sel_e     pc_sel_c;
    wb_sel_e     wb_sel_c;
    imm_sel_e    imm_sel_c;

    // Branch condition is resolved by the ALU, so funct3 needs no decode here.
    logic        funct3_unused;
    assign funct3_unused = ^funct3;

    rv32i_op_class u_op_class (
        .opcode  (opcode),
        .cls_c   (cls),
        .legal_c (legal)
    );

    // State register; reset restarts at FETCH and abandons any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe/select decode from state and the latched opcode.
    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        addr_sel_c  = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_sel_c    = PC_PLUS4;
        reg_we_c    = 1'b0;
        wb_sel_c    = WB_ALU;
        alu_a_sel_c = 1'b0;
        alu_b_sel_c = 1'b0;
        imm_sel_c   = IMM_I;
        illegal_c   = 1'b0;

        // IR is only valid after FETCH, so class-driven selects start at DECODE.
        if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            imm_sel_c   = imm_sel_for(cls);
            alu_a_sel_c = cls.auipc;
            alu_b_sel_c = ~(cls.op | cls.branch);
        end

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (cls.branch) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = br_taken ? PC_PLUS_IMM : PC_PLUS4;
                    state_d  = S_FETCH;
                end else if (cls.fence) begin
                    pc_we_c  = 1'b1;
                    state_d  = S_FETCH;
                end else if (cls.load || cls.store) begin
                    state_d  = S_MEM;
                end else begin
                    state_d  = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c  = 1'b1;
                addr_sel_c = 1'b1;
                mem_we_c   = cls.store;
                if (mem_ready) begin
                    if (cls.store) begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                pc_we_c  = 1'b1;
                state_d  = S_FETCH;
                if (cls.jal) begin
                    wb_sel_c = WB_PC4;
                    pc_sel_c = PC_PLUS_IMM;
                end else if (cls.jalr) begin
                    wb_sel_c = WB_PC4;
                    pc_sel_c = PC_ALU;
                end else if (cls.lui) begin
                    wb_sel_c = WB_IMM;
                end else if (cls.load) begin
                    wb_sel_c = WB_LOAD;
                end
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Hold every output low while reset is asserted.
    assign mem_req   = mem_req_c   & ~rst;
    assign mem_we    = mem_we_c    & ~rst;
    assign addr_sel  = addr_sel_c  & ~rst;
    assign ir_we     = ir_we_c     & ~rst;
    assign pc_we     = pc_we_c     & ~rst;
    assign reg_we    = reg_we_c    & ~rst;
    assign alu_a_sel = alu_a_sel_c & ~rst;
    assign alu_b_sel = alu_b_sel_c & ~rst;
    assign illegal   = illegal_c   & ~rst;
    assign pc_sel    = rst ? 2'(PC_PLUS4) : 2'(pc_sel_c);
    assign wb_sel    = rst ? 2'(WB_ALU)   : 2'(wb_sel_c);
    assign imm_sel   = rst ? 3'(IMM_I)    : 3'(imm_sel_c);

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    // Cycles count outside TRAP; retirements count on each PC update.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + ((state_q != S_TRAP) ? CNT_W'(1) : CNT_W'(0));
        instret_cnt_d = instret_cnt_q + (pc_we_c ? CNT_W'(1) : CNT_W'(0));
    end

    // Counter registers, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed self-checking bench for rv32i_multicycle_ctrl.
// Strobe vector layout: {mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, illegal}.
module tb_rv32i_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we;
    logic [1:0]  pc_sel, wb_sel;
    logic        alu_a_sel, alu_b_sel;
    logic [2:0]  imm_sel;
    logic        illegal;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32i_multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct3      (funct3),
        .br_taken    (br_taken),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .alu_a_sel   (alu_a_sel),
        .alu_b_sel   (alu_b_sel),
        .imm_sel     (imm_sel),
        .illegal     (illegal)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    function automatic logic [6:0] st();
        return {mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, illegal};
    endfunction

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b0; opcode = '0; funct3 = '0; br_taken = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (st() !== 7'b0000000 || {pc_sel, wb_sel, imm_sel, alu_a_sel, alu_b_sel} !== 9'd0) begin
            errors++; $display("FAIL reset_outputs: got st=%b sel=%b expected all 0", st(), {pc_sel, wb_sel, imm_sel, alu_a_sel, alu_b_sel});
        end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
        end
`endif
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (st() !== 7'b1000000) begin
            errors++; $display("FAIL reset_release_fetch: got %b expected 1000000", st());
        end
    endtask

    task automatic test_addi();
        @(negedge clk); opcode = 7'b0010011; mem_ready = 1'b1; #1;
        checks++;
        if (st() !== 7'b1001000) begin errors++; $display("FAIL addi_fetch: got %b expected 1001000", st()); end
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (st() !== 7'b0000000 || imm_sel !== 3'd0) begin
            errors++; $display("FAIL addi_decode: got st=%b imm=%0d expected 0000000 imm=0", st(), imm_sel);
        end
        @(negedge clk); #1;
        checks++;
        if (st() !== 7'b0000000 || alu_b_sel !== 1'b1) begin
            errors++; $display("FAIL addi_exec: got st=%b b=%b expected 0000000 b=1", st(), alu_b_sel);
        end
        @(negedge clk); #1;
        checks++;
        if (st() !== 7'b0000110 || wb_sel !== 2'd0 || pc_sel !== 2'd0) begin
            errors++; $display("FAIL addi_wb: got st=%b wb=%0d pc=%0d expected 0000110 wb=0 pc=0", st(), wb_sel, pc_sel);
        end
    endtask

    task automatic test_lw_waits();
        logic [6:0] exp [8] = '{7'b1000000, 7'b1000000, 7'b1001000, 7'b0000000,
                                7'b0000000, 7'b1010000, 7'b1010000, 7'b0000110};
        logic       rdy [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); opcode = 7'b0000011; mem_ready = rdy[c]; #1;
            checks++;
            if (st() !== exp[c]) begin
                errors++; $display("FAIL lw_cycle%0d: got %b expected %b", c + 1, st(), exp[c]);
            end
        end
        checks++;
        if (wb_sel !== 2'd1 || pc_sel !== 2'd0) begin
            errors++; $display("FAIL lw_wb_sel: got wb=%0d pc=%0d expected wb=1 pc=0", wb_sel, pc_sel);
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (st() !== 7'b1000000) begin errors++; $display("FAIL lw_next_fetch: got %b expected 1000000", st()); end
    endtask

    task automatic test_branch();
        for (int t = 1; t >= 0; t--) begin
            @(negedge clk); opcode = 7'b1100011; mem_ready = 1'b1; br_taken = 1'b0; #1;
            checks++;
            if (st() !== 7'b1001000) begin errors++; $display("FAIL beq%0d_fetch: got %b expected 1001000", t, st()); end
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++;
            if (st() !== 7'b0000000 || imm_sel !== 3'd2) begin
                errors++; $display("FAIL beq%0d_decode: got st=%b imm=%0d expected 0000000 imm=2", t, st(), imm_sel);
            end
            @(negedge clk); br_taken = 1'(t); #1;
            checks++;
            if (st() !== 7'b0000100 || pc_sel !== 2'(t)) begin
                errors++; $display("FAIL beq%0d_exec: got st=%b pc=%0d expected 0000100 pc=%0d", t, st(), pc_sel, t);
            end
            @(negedge clk); br_taken = 1'b0; #1;
            checks++;
            if (st() !== 7'b1000000) begin errors++; $display("FAIL beq%0d_next_fetch: got %b expected 1000000", t, st()); end
        end
    endtask

    task automatic test_jalr();
        @(negedge clk); opcode = 7'b1100111; mem_ready = 1'b1; #1;
        checks++;
        if (st() !== 7'b1001000) begin errors++; $display("FAIL jalr_fetch: got %b expected 1001000", st()); end
        @(negedge clk); mem_ready = 1'b0; #1;
        @(negedge clk); #1;
        checks++;
        if (st() !== 7'b0000000) begin errors++; $display("FAIL jalr_exec: got %b expected 0000000", st()); end
        @(negedge clk); #1;
        checks++;
        if (st() !== 7'b0000110 || wb_sel !== 2'd2 || pc_sel !== 2'd2 || imm_sel !== 3'd0) begin
            errors++; $display("FAIL jalr_wb: got st=%b wb=%0d pc=%0d imm=%0d expected 0000110 wb=2 pc=2 imm=0", st(), wb_sel, pc_sel, imm_sel);
        end
    endtask

    task automatic test_store();
        @(negedge clk); opcode = 7'b0100011; mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (imm_sel !== 3'd1) begin errors++; $display("FAIL sw_decode_imm: got %0d expected 1", imm_sel); end
        @(negedge clk); #1;
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++;
        if (st() !== 7'b1110100 || pc_sel !== 2'd0) begin
            errors++; $display("FAIL sw_mem: got st=%b pc=%0d expected 1110100 pc=0", st(), pc_sel);
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (st() !== 7'b1000000) begin errors++; $display("FAIL sw_next_fetch: got %b expected 1000000", st()); end
    endtask

    task automatic test_back_to_back_classes();
        logic [6:0] opc   [4] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
        logic [1:0] exp_wb[4] = '{2'd3, 2'd0, 2'd2, 2'd0};
        logic [1:0] exp_pc[4] = '{2'd0, 2'd0, 2'd1, 2'd0};
        logic [2:0] exp_im[4] = '{3'd3, 3'd3, 3'd4, 3'd0};
        logic       chk_im[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp_ab[4] = '{2'b00, 2'b11, 2'b00, 2'b00};
        logic       chk_ab[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); opcode = opc[i]; mem_ready = 1'b1; #1;
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++;
            if (chk_im[i] && imm_sel !== exp_im[i]) begin
                errors++; $display("FAIL class%0d_imm: got %0d expected %0d", i, imm_sel, exp_im[i]);
            end
            @(negedge clk); #1;
            checks++;
            if (st() !== 7'b0000000 || (chk_ab[i] && {alu_a_sel, alu_b_sel} !== exp_ab[i])) begin
                errors++; $display("FAIL class%0d_exec: got st=%b ab=%b expected 0000000 ab=%b", i, st(), {alu_a_sel, alu_b_sel}, exp_ab[i]);
            end
            @(negedge clk); #1;
            checks++;
            if (st() !== 7'b0000110 || wb_sel !== exp_wb[i] || pc_sel !== exp_pc[i]) begin
                errors++; $display("FAIL class%0d_wb: got st=%b wb=%0d pc=%0d expected 0000110 wb=%0d pc=%0d", i, st(), wb_sel, pc_sel, exp_wb[i], exp_pc[i]);
            end
        end
    endtask

    task automatic test_fence();
        @(negedge clk); opcode = 7'b0001111; mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        @(negedge clk); #1;
        checks++;
        if (st() !== 7'b0000100 || pc_sel !== 2'd0) begin
            errors++; $display("FAIL fence_exec: got st=%b pc=%0d expected 0000100 pc=0", st(), pc_sel);
        end
        @(negedge clk); #1;
        checks++;
        if (st() !== 7'b1000000) begin errors++; $display("FAIL fence_next_fetch: got %b expected 1000000", st()); end
    endtask

    task automatic test_illegal();
        @(negedge clk); opcode = 7'b0000000; mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (st() !== 7'b0000000) begin errors++; $display("FAIL illegal_decode: got %b expected 0000000", st()); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); mem_ready = 1'b1; br_taken = c[0]; opcode = 7'b0010011; #1;
            checks++;
            if (st() !== 7'b0000001) begin
                errors++; $display("FAIL trap_cycle%0d: got %b expected 0000001", c, st());
            end
        end
        @(negedge clk); rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0; #1;
        checks++;
        if (st() !== 7'b0000000) begin errors++; $display("FAIL trap_reset: got %b expected 0000000", st()); end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (st() !== 7'b1000000) begin errors++; $display("FAIL trap_exit_fetch: got %b expected 1000000", st()); end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk); opcode = 7'b0100011; mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        @(negedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            checks++;
            if (st() !== 7'b1110000) begin errors++; $display("FAIL sw_mem_wait%0d: got %b expected 1110000", c, st()); end
        end
        #2 rst = 1'b1; #1;
        checks++;
        if (st() !== 7'b0000000 || {pc_sel, wb_sel, imm_sel, alu_a_sel, alu_b_sel} !== 9'd0) begin
            errors++; $display("FAIL mid_access_reset: got st=%b sel=%b expected all 0", st(), {pc_sel, wb_sel, imm_sel, alu_a_sel, alu_b_sel});
        end
        @(negedge clk); #1;
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
        end
`endif
        @(negedge clk); rst = 1'b0; opcode = 7'b0010011; mem_ready = 1'b1; #1;
        checks++;
        if (st() !== 7'b1001000) begin errors++; $display("FAIL mid_reset_release: got %b expected 1001000", st()); end
    endtask

    task automatic test_back_to_back_addi();
        logic [6:0] phase_exp [4] = '{7'b1001000, 7'b0000000, 7'b0000000, 7'b0000110};
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk); #1;
            checks++;
            if (st() !== phase_exp[(c - 1) % 4]) begin
                errors++; $display("FAIL b2b_cycle%0d: got %b expected %b", c, st(), phase_exp[(c - 1) % 4]);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (st() !== 7'b1001000) begin errors++; $display("FAIL b2b_fourth_fetch: got %b expected 1001000", st()); end
`ifdef CTRL_PERF_CNT_EN
        checks++;
        if (cycle_cnt !== 32'd12 || instret_cnt !== 32'd3) begin
            errors++; $display("FAIL perf_counters: got cycle=%0d instret=%0d expected cycle=12 instret=3", cycle_cnt, instret_cnt);
        end
`endif
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw_waits();
        test_branch();
        test_jalr();
        test_store();
        test_back_to_back_classes();
        test_fence();
        test_illegal();
        test_reset_mid_access();
        test_back_to_back_addi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
